// File: rtl/probe_message_stream.sv
// probe_message_stream: packs checkpoint events into header + payload byte messages on a valid/ready stream.
// Optional feature macro PROBE_DROP_COUNT_EN appends a saturating drop-count trailer byte to overflowed messages.
module probe_message_stream #(
    parameter int NUM_CP   = 2,
    parameter int CP_BYTES = 3,
    parameter int DELAY_W  = 13
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [NUM_CP-1:0]            cp_en_in,
    input  logic [NUM_CP*CP_BYTES*8-1:0] cp_payload_in,
    output logic [7:0]                   out_data,
    output logic                         out_valid,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic                         busy
);
    // state | meaning
    // IDLE  | nothing in flight, any trigger is captured
    // SEND  | streaming the buffered message, new events are dropped
    localparam int HDR_W     = DELAY_W + NUM_CP + 1;
    localparam int HDR_BYTES = (HDR_W + 7) / 8;
    localparam int HDR_PW    = HDR_BYTES * 8;
    localparam int CP_W      = CP_BYTES * 8;
`ifdef PROBE_DROP_COUNT_EN
    localparam int TRL_BYTES = 1;
`else
    localparam int TRL_BYTES = 0;
`endif
    localparam int MAX_BYTES = HDR_BYTES + NUM_CP * CP_BYTES + TRL_BYTES;
    localparam int MSG_W     = MAX_BYTES * 8;
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);
    localparam logic [DELAY_W-1:0] DELAY_MAX = '1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [MSG_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic               ovf_q, ovf_d;
`ifdef PROBE_DROP_COUNT_EN
    logic [7:0]         drop_cnt_q, drop_cnt_d;
`endif

    logic [HDR_PW-1:0]  hdr;
    logic [MSG_W-1:0]   msg;
    logic [CNT_W-1:0]   msg_len;
    int                 pos;
    logic               hs, last_hs, can_accept, trigger, capture, drop;

    // Enabled payloads are packed densely after the header in ascending checkpoint order.
    always_comb begin
        hdr = HDR_PW'({delay_q, ovf_q, cp_en_in});
        msg = MSG_W'(hdr);
        pos = HDR_BYTES;
        for (int k = 0; k < NUM_CP; k++) begin
            if (cp_en_in[k]) begin
                msg = msg | (MSG_W'(CP_W'(cp_payload_in >> (k * CP_W))) << (pos * 8));
                pos = pos + CP_BYTES;
            end
        end
`ifdef PROBE_DROP_COUNT_EN
        if (ovf_q) begin
            msg = msg | (MSG_W'(drop_cnt_q) << (pos * 8));
            pos = pos + 1;
        end
`endif
        msg_len = CNT_W'(pos);
    end

    always_comb begin
        hs         = out_valid_q && out_ready;
        last_hs    = (state_q == SEND) && hs && out_last_q;
        can_accept = (state_q == IDLE) || last_hs;
        trigger    = (|cp_en_in) || (delay_q == DELAY_MAX);
        capture    = trigger && can_accept;
        drop       = (|cp_en_in) && !can_accept;

        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        shift_d     = shift_q;
        rem_d       = rem_q;

        if (capture) begin
            state_d     = SEND;
            out_valid_d = 1'b1;
            out_data_d  = msg[7:0];
            out_last_d  = (msg_len == CNT_W'(1));
            shift_d     = msg >> 8;
            rem_d       = msg_len - CNT_W'(1);
        end else if ((state_q == SEND) && hs) begin
            if (out_last_q) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end else begin
                out_data_d  = shift_q[7:0];
                out_last_d  = (rem_q == CNT_W'(1));
                shift_d     = shift_q >> 8;
                rem_d       = rem_q - CNT_W'(1);
            end
        end

        // Saturation keeps the heartbeat trigger pending while a message is in flight.
        if (capture)
            delay_d = DELAY_W'(1);
        else if (delay_q != DELAY_MAX)
            delay_d = delay_q + DELAY_W'(1);
        else
            delay_d = delay_q;

        if (capture)
            ovf_d = 1'b0;
        else if (drop)
            ovf_d = 1'b1;
        else
            ovf_d = ovf_q;

`ifdef PROBE_DROP_COUNT_EN
        if (capture && ovf_q)
            drop_cnt_d = drop ? 8'd1 : 8'd0;
        else if (drop && (drop_cnt_q != 8'hFF))
            drop_cnt_d = drop_cnt_q + 8'd1;
        else
            drop_cnt_d = drop_cnt_q;
`endif
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            shift_q     <= '0;
            rem_q       <= '0;
            delay_q     <= DELAY_W'(1);
            ovf_q       <= 1'b0;
`ifdef PROBE_DROP_COUNT_EN
            drop_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            shift_q     <= shift_d;
            rem_q       <= rem_d;
            delay_q     <= delay_d;
            ovf_q       <= ovf_d;
`ifdef PROBE_DROP_COUNT_EN
            drop_cnt_q  <= drop_cnt_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == SEND);

endmodule

// File: tb/tb_probe_message_stream.sv
// Directed bench for probe_message_stream with default parameters (2 checkpoints, 3-byte payloads, 13-bit delay).
module tb_probe_message_stream;
    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [1:0]  cp_en_in;
    logic [47:0] cp_payload_in;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n;
    logic [7:0] exp_q[$];

`ifdef PROBE_DROP_COUNT_EN
    localparam int TRL = 1;
`else
    localparam int TRL = 0;
`endif

    always #5 clk_in = ~clk_in;

    probe_message_stream dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .cp_en_in     (cp_en_in),
        .cp_payload_in(cp_payload_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walks exp_q with out_ready high; final_tick=0 leaves the last byte on the bus for the caller.
    task automatic collect(input string tag, input bit final_tick);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_valid%0d", tag, i), 32'(out_valid), 32'd1);
            chk($sformatf("%s_data%0d", tag, i), 32'(out_data), 32'(exp_q[i]));
            chk($sformatf("%s_last%0d", tag, i), 32'(out_last), (i == exp_q.size() - 1) ? 32'd1 : 32'd0);
            if ((i < exp_q.size() - 1) || final_tick) tick();
        end
        if (final_tick) begin
            chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
            chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst_n_in      = 1'b0;
        cp_en_in      = 2'b00;
        cp_payload_in = '0;
        out_ready     = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Heartbeat: delay counter climbs from 1 to 8191, then a header-only message.
        rst_n_in = 1'b1;
        n = 0;
        while (!out_valid && n < 9000) begin
            tick();
            n++;
        end
        chk("hb_latency", 32'(n), 32'd8191);
        exp_q = '{8'hF8, 8'hFF};
        collect("hb", 1'b1);

        // Single checkpoint captured at delay 5.
        tick();
        tick();
        cp_en_in      = 2'b01;
        cp_payload_in = 48'h000000_ABCDEF;
        tick();
        cp_en_in = 2'b00;
        exp_q = '{8'h29, 8'h00, 8'hEF, 8'hCD, 8'hAB};
        collect("cp0", 1'b1);

        // Back-to-back: a new event lands on the final-byte handshake.
        cp_en_in      = 2'b01;
        cp_payload_in = 48'h000000_010203;
        tick();
        cp_en_in = 2'b00;
        exp_q = '{8'h31, 8'h00, 8'h03, 8'h02, 8'h01};
        collect("b2b_a", 1'b0);
        cp_en_in      = 2'b11;
        cp_payload_in = {24'h445566, 24'h112233};
        tick();
        cp_en_in = 2'b00;
        chk("b2b_busy", 32'(busy), 32'd1);
        exp_q = '{8'h2B, 8'h00, 8'h33, 8'h22, 8'h11, 8'h66, 8'h55, 8'h44};
        collect("b2b_b", 1'b1);

        // Backpressure holds the byte; an event while busy is dropped.
        out_ready     = 1'b0;
        cp_en_in      = 2'b01;
        cp_payload_in = 48'h000000_A1B2C3;
        tick();
        cp_en_in = 2'b00;
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data0", 32'(out_data), 32'h49);
        tick();
        chk("hold_data1", 32'(out_data), 32'h49);
        chk("hold_last", 32'(out_last), 32'd0);
        cp_en_in      = 2'b10;
        cp_payload_in = 48'hDEADBE_000000;
        tick();
        cp_en_in = 2'b00;
        chk("hold_data2", 32'(out_data), 32'h49);
        chk("hold_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        exp_q = '{8'h49, 8'h00, 8'hC3, 8'hB2, 8'hA1};
        collect("held", 1'b1);

        cp_en_in      = 2'b01;
        cp_payload_in = 48'h000000_5A6B7C;
        tick();
        cp_en_in = 2'b00;
        exp_q = '{8'h45, 8'h00, 8'h7C, 8'h6B, 8'h5A};
        if (TRL == 1) exp_q.push_back(8'h01);
        collect("ovf", 1'b1);

        // Reset at byte 3 abandons the message; the next one starts cleanly.
        cp_en_in      = 2'b01;
        cp_payload_in = 48'h000000_998877;
        tick();
        cp_en_in = 2'b00;
        chk("pre_rst_hdr", 32'(out_data), (TRL == 1) ? 32'h39 : 32'h31);
        tick();
        tick();
        tick();
        chk("pre_rst_byte3", 32'(out_data), 32'h88);
        rst_n_in = 1'b0;
        tick();
        rst_n_in = 1'b1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        tick();
        cp_en_in      = 2'b11;
        cp_payload_in = {24'h445566, 24'h112233};
        tick();
        cp_en_in = 2'b00;
        exp_q = '{8'h13, 8'h00, 8'h33, 8'h22, 8'h11, 8'h66, 8'h55, 8'h44};
        collect("post_rst", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
